// File: rtl/cc_frame_ctrl.sv
// rtl/cc_frame_ctrl.sv - frame sequencer between the UART rx/tx pair and the byte-wide cipher core
//
// Collects SYNC, LEN, payload from the UART receiver. Streams the payload through the
// cipher core, writing results back in place. Then sends SYNC, LEN, results to the transmitter.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rx_data / rx_valid             received byte, one-cycle pulse per byte
//   core_in_data / core_in_valid   byte offered to the core, held until core_in_ready
//   core_in_ready                  core accepts a byte when valid and ready are both high
//   core_out_data / core_out_valid processed byte from the core, one-cycle pulse, in order
//   tx_data / tx_start             byte to transmit, one-cycle transmit request
//   tx_busy                        transmitter busy, rises the cycle after tx_start
//   busy                           high whenever a frame is in progress
//   frame_err                      one-cycle pulse when a frame is aborted
module cc_frame_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] core_in_data,
  output logic       core_in_valid,
  input  logic       core_in_ready,
  input  logic [7:0] core_out_data,
  input  logic       core_out_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       frame_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  // One extra index bit so that LEN == DEPTH is representable without wrapping.
  localparam int unsigned IW = AW + 1;
  // The transmit count also covers the SYNC and LEN bytes.
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [IW-1:0] I_ONE   = IW'(1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_TWO   = CW'(2);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT - 1);
  localparam logic [8:0]    LEN_MAX = 9'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, GET_DATA, PROC, TX_SYNC, TX_LEN, TX_DATA, TX_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   len_q, len_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic [IW-1:0]   in_idx_q, in_idx_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            guard_q, guard_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            frame_err_q, frame_err_d;

  logic [7:0]      buf_q [DEPTH];
  logic            buf_we;
  logic [AW-1:0]   buf_waddr;
  logic [7:0]      buf_wdata;

  logic            reload;
  logic            timed;

  assign busy          = (state_q != IDLE);
  assign core_in_valid = (state_q == PROC) && (in_idx_q < len_q);
  assign core_in_data  = core_in_valid ? buf_q[in_idx_q[AW-1:0]] : 8'h00;
  // tx_start is decoded from the state so it appears in the cycle the TX state is entered;
  // tx_data is registered on the transition so it is already valid in that cycle.
  assign tx_start      = (state_q == TX_SYNC) || (state_q == TX_LEN) || (state_q == TX_DATA);
  assign tx_data       = tx_data_q;
  assign frame_err     = frame_err_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    tx_cnt_d    = tx_cnt_q;
    timer_d     = timer_q;
    guard_d     = guard_q;
    tx_data_d   = tx_data_q;
    frame_err_d = 1'b0;
    buf_we      = 1'b0;
    buf_waddr   = '0;
    buf_wdata   = 8'h00;
    reload      = 1'b0;
    timed       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC)) begin
          state_d = GET_LEN;
        end
      end

      GET_LEN: begin
        timed = 1'b1;
        if (rx_valid) begin
          reload = 1'b1;
          if ((rx_data != 8'h00) && ({1'b0, rx_data} <= LEN_MAX)) begin
            len_d    = IW'(rx_data);
            wr_idx_d = '0;
            state_d  = GET_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      GET_DATA: begin
        timed = 1'b1;
        if (rx_valid) begin
          reload    = 1'b1;
          buf_we    = 1'b1;
          buf_waddr = wr_idx_q[AW-1:0];
          buf_wdata = rx_data;
          wr_idx_d  = wr_idx_q + I_ONE;
          if (wr_idx_d == len_q) begin
            in_idx_d  = '0;
            out_idx_d = '0;
            state_d   = PROC;
          end
        end
      end

      PROC: begin
        timed = 1'b1;
        if (core_in_valid && core_in_ready) begin
          in_idx_d = in_idx_q + I_ONE;
        end
        // Results overwrite their source slot; out_idx never passes in_idx, so the
        // byte currently offered to the core is never clobbered.
        if (core_out_valid && (out_idx_q < len_q)) begin
          reload    = 1'b1;
          buf_we    = 1'b1;
          buf_waddr = out_idx_q[AW-1:0];
          buf_wdata = core_out_data;
          out_idx_d = out_idx_q + I_ONE;
          if (out_idx_d == len_q) begin
            tx_cnt_d  = '0;
            tx_data_d = SYNC;
            state_d   = TX_SYNC;
          end
        end
      end

      TX_SYNC, TX_LEN, TX_DATA: begin
        tx_cnt_d = tx_cnt_q + C_ONE;
        guard_d  = 1'b1;
        state_d  = TX_WAIT;
      end

      TX_WAIT: begin
        // The guard cycle covers the cycle in which tx_busy has not yet risen.
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!tx_busy) begin
          if (tx_cnt_q == C_ONE) begin
            tx_data_d = 8'(len_q);
            state_d   = TX_LEN;
          end else if (tx_cnt_q < ({1'b0, len_q} + C_TWO)) begin
            tx_data_d = buf_q[AW'(tx_cnt_q - C_TWO)];
            state_d   = TX_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // Inter-event watchdog for the receive and processing phases.
    if (reload) begin
      timer_d = '0;
    end else if (timed) begin
      if (timer_q == T_MAX) begin
        timer_d     = '0;
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        timer_d = timer_q + T_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      tx_cnt_q    <= '0;
      timer_q     <= '0;
      guard_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      tx_cnt_q    <= tx_cnt_d;
      timer_q     <= timer_d;
      guard_q     <= guard_d;
      tx_data_q   <= tx_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Payload buffer has no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (buf_we && !rst) begin
      buf_q[buf_waddr] <= buf_wdata;
    end
  end
endmodule

// File: tb/tb_cc_frame_ctrl.sv
// tb/tb_cc_frame_ctrl.sv - scoreboard bench for cc_frame_ctrl with core and transmitter models
module tb_cc_frame_ctrl;
  localparam int         DEPTH   = 16;
  localparam int         TIMEOUT = 200;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] core_in_data;
  logic       core_in_valid;
  logic       core_in_ready;
  logic [7:0] core_out_data;
  logic       core_out_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  cc_frame_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .busy(busy), .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard state: expected transmit bytes and the number of expected aborts.
  logic [7:0] exp_tx[$];
  int         err_pending = 0;
  int         n_civ = 0;
  int         n_txs = 0;

  // Core model knobs.
  logic [7:0] key = 8'h00;
  int         lat = 4;
  int         ready_mode = 0;
  bit         spur_en = 1'b0;
  int         cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] d;
  } pend_t;
  pend_t pend[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cipher core model: out = in ^ key after 'lat' cycles, in order.
  initial begin
    pend_t e;
    core_in_ready  = 1'b1;
    core_out_valid = 1'b0;
    core_out_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0:       core_in_ready = 1'b1;
        1:       core_in_ready = ~core_in_ready;
        default: core_in_ready = 1'($urandom_range(0, 1));
      endcase
      if (core_in_valid && core_in_ready) begin
        e.due = cyc + lat;
        e.d   = core_in_data ^ key;
        pend.push_back(e);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        core_out_valid = 1'b1;
        core_out_data  = pend[0].d;
        pend.delete(0);
      end else if (spur_en && pend.size() == 0 && !core_in_valid && $urandom_range(0, 3) == 0) begin
        core_out_valid = 1'b1;
        core_out_data  = 8'($urandom);
      end else begin
        core_out_valid = 1'b0;
        core_out_data  = 8'h00;
      end
    end
  end

  // Transmitter model plus output monitor.
  initial begin
    int         busy_left;
    int         since_start;
    logic [7:0] held;
    bit         stable;
    busy_left   = 0;
    since_start = 100;
    held        = 8'h00;
    stable      = 1'b1;
    tx_busy     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy   = 1'b0;
        busy_left = 0;
        continue;
      end
      since_start++;
      if (core_in_valid) n_civ++;
      if (tx_busy) begin
        if (tx_data !== held) stable = 1'b0;
        busy_left--;
        if (busy_left <= 0) begin
          tx_busy = 1'b0;
          check("tx_data_stable", int'(stable), 1);
        end
      end
      if (tx_start) begin
        n_txs++;
        check("tx_start_spacing", int'(since_start >= 3), 1);
        since_start = 0;
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h, no byte expected", tx_data);
        end else begin
          check("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
        end
        held      = tx_data;
        stable    = 1'b1;
        tx_busy   = 1'b1;
        busy_left = $urandom_range(2, 6);
      end
      if (frame_err) begin
        check("frame_err_busy_low", int'(busy), 0);
        check("frame_err_expected", int'(err_pending > 0), 1);
        if (err_pending > 0) err_pending--;
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Reference: response is SYNC, LEN, then each payload byte transformed by the core.
  task automatic send_frame(input logic [7:0] p[$], input int gmax);
    exp_tx.push_back(SYNC);
    exp_tx.push_back(8'(p.size()));
    foreach (p[i]) exp_tx.push_back(p[i] ^ key);
    rx_byte(SYNC, $urandom_range(0, gmax));
    check("busy_after_sync", int'(busy), 1);
    rx_byte(8'(p.size()), $urandom_range(0, gmax));
    foreach (p[i]) rx_byte(p[i], $urandom_range(0, gmax));
    check("core_in_valid_rise", int'(core_in_valid), 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, int'(busy), 0);
    check({name, "_tx_drained"}, exp_tx.size(), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_start"}, int'(tx_start), 0);
    check({name, "_tx_data"}, int'(tx_data), 0);
    check({name, "_core_in_valid"}, int'(core_in_valid), 0);
    check({name, "_core_in_data"}, int'(core_in_data), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_frame_err"}, int'(frame_err), 0);
  endtask

  task automatic inject_while_busy();
    forever begin
      @(negedge clk);
      if (busy && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation stalled");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pl[$];
    logic [7:0] b;
    int         civ0;
    int         txs0;
    int         n;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal: XOR FF core with latency 4
    key = 8'hFF; lat = 4; ready_mode = 0;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(pl, 0);
    wait_idle(1000, "nominal");

    // Bad lengths 0 and DEPTH+1
    civ0 = n_civ; txs0 = n_txs;
    err_pending++;
    rx_byte(SYNC, 1);
    rx_byte(8'h00, 1);
    repeat (3) @(negedge clk);
    check("badlen0_err_seen", err_pending, 0);
    check("badlen0_busy", int'(busy), 0);
    err_pending++;
    rx_byte(SYNC, 1);
    rx_byte(8'(DEPTH + 1), 1);
    repeat (3) @(negedge clk);
    check("badlen17_err_seen", err_pending, 0);
    check("badlen_no_core", n_civ - civ0, 0);
    check("badlen_no_tx", n_txs - txs0, 0);

    // Full buffer, pass-through core
    key = 8'h00; lat = 2;
    pl.delete();
    for (int i = 0; i < DEPTH; i++) pl.push_back(8'(i));
    send_frame(pl, 1);
    wait_idle(2000, "full");

    // Timeout during GET_DATA, then a good frame
    err_pending++;
    rx_byte(SYNC, 0);
    rx_byte(8'h02, 0);
    rx_byte(8'h55, 0);
    n = 0;
    while (err_pending > 0 && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_err_seen", err_pending, 0);
    check("timeout_idle", int'(busy), 0);
    key = 8'h3C; lat = 3;
    pl = '{8'h5A, 8'hC3};
    send_frame(pl, 2);
    wait_idle(1000, "after_timeout");

    // Backpressure, spurious core outputs, rx injected during PROC/TX
    key = 8'h96; lat = 5; ready_mode = 1; spur_en = 1'b1;
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    send_frame(pl, 1);
    fork
      inject_while_busy();
      wait_idle(2000, "backpressure");
    join_any
    disable fork;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    spur_en  = 1'b0;
    ready_mode = 0;
    repeat (2) @(negedge clk);

    // Reset during TX_DATA
    key = 8'h0F; lat = 1;
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    send_frame(pl, 0);
    n = 0;
    while (!(tx_start && n_txs >= 3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_tx_data", int'(tx_start), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midtx_reset");
    exp_tx.delete();
    pend.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(pl, 1);
    wait_idle(1000, "after_reset");

    // Randomised frames with leading junk
    for (int f = 0; f < 6; f++) begin
      key        = 8'($urandom);
      lat        = $urandom_range(1, 6);
      ready_mode = $urandom_range(0, 2);
      for (int j = 0; j < 2; j++) begin
        do b = 8'($urandom); while (b == SYNC);
        rx_byte(b, $urandom_range(0, 2));
      end
      pl.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      send_frame(pl, 3);
      wait_idle(3000, "random");
    end

    repeat (5) @(negedge clk);
    check("final_err_pending", err_pending, 0);
    check("final_core_pending", pend.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
